// File: rtl/tl_width_narrower.sv
// TileLink-UL width narrower: wide client port (IN_BYTES/beat) to narrow
// manager port (OUT_BYTES/beat).
//   auto_in_a_*  : client A channel (wide). Puts are split into narrow beats,
//                  Gets are forwarded as a single narrow beat.
//   auto_out_a_* : manager A channel (narrow).
//   auto_out_d_* : manager D channel (narrow). AccessAckData beats of a group
//                  are gathered; the last beat completes the wide beat.
//   auto_in_d_*  : client D channel (wide).
//   clock/reset  : single clock, asynchronous active-high reset.
module tl_width_narrower #(
  parameter int IN_BYTES    = 8,
  parameter int OUT_BYTES   = 4,
  parameter int ADDR_BITS   = 31,
  parameter int SOURCE_BITS = 3,
  parameter int SIZE_BITS   = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic                     auto_in_a_ready,
  input  logic                     auto_in_a_valid,
  input  logic [2:0]               auto_in_a_bits_opcode,
  input  logic [2:0]               auto_in_a_bits_param,
  input  logic [SIZE_BITS-1:0]     auto_in_a_bits_size,
  input  logic [SOURCE_BITS-1:0]   auto_in_a_bits_source,
  input  logic [ADDR_BITS-1:0]     auto_in_a_bits_address,
  input  logic [IN_BYTES-1:0]      auto_in_a_bits_mask,
  input  logic [8*IN_BYTES-1:0]    auto_in_a_bits_data,
  input  logic                     auto_in_a_bits_corrupt,
  input  logic                     auto_in_d_ready,
  output logic                     auto_in_d_valid,
  output logic [2:0]               auto_in_d_bits_opcode,
  output logic [1:0]               auto_in_d_bits_param,
  output logic [SIZE_BITS-1:0]     auto_in_d_bits_size,
  output logic [SOURCE_BITS-1:0]   auto_in_d_bits_source,
  output logic                     auto_in_d_bits_sink,
  output logic                     auto_in_d_bits_denied,
  output logic [8*IN_BYTES-1:0]    auto_in_d_bits_data,
  output logic                     auto_in_d_bits_corrupt,
  input  logic                     auto_out_a_ready,
  output logic                     auto_out_a_valid,
  output logic [2:0]               auto_out_a_bits_opcode,
  output logic [2:0]               auto_out_a_bits_param,
  output logic [SIZE_BITS-1:0]     auto_out_a_bits_size,
  output logic [SOURCE_BITS-1:0]   auto_out_a_bits_source,
  output logic [ADDR_BITS-1:0]     auto_out_a_bits_address,
  output logic [OUT_BYTES-1:0]     auto_out_a_bits_mask,
  output logic [8*OUT_BYTES-1:0]   auto_out_a_bits_data,
  output logic                     auto_out_a_bits_corrupt,
  output logic                     auto_out_d_ready,
  input  logic                     auto_out_d_valid,
  input  logic [2:0]               auto_out_d_bits_opcode,
  input  logic [1:0]               auto_out_d_bits_param,
  input  logic [SIZE_BITS-1:0]     auto_out_d_bits_size,
  input  logic [SOURCE_BITS-1:0]   auto_out_d_bits_source,
  input  logic                     auto_out_d_bits_sink,
  input  logic                     auto_out_d_bits_denied,
  input  logic [8*OUT_BYTES-1:0]   auto_out_d_bits_data,
  input  logic                     auto_out_d_bits_corrupt
);

  localparam int RATIO = IN_BYTES / OUT_BYTES;
  localparam int LR    = $clog2(RATIO);
  localparam int LO    = $clog2(OUT_BYTES);
  localparam int OW    = 8 * OUT_BYTES;

  // Index of the last narrow beat of a group (n-1) for a given lg-size.
  function automatic logic [LR-1:0] grp_last(input logic [SIZE_BITS-1:0] size);
    int lg;
    lg = int'(size) - LO;
    if (lg < 0)  lg = 0;
    if (lg > LR) lg = LR;
    return LR'((1 << lg) - 1);
  endfunction

  // ---------------- A channel split ----------------
  logic [LR-1:0] a_idx;
  logic [LR-1:0] a_last;
  logic [LR-1:0] a_lane;
  logic          a_put;

  always_comb begin
    a_last = grp_last(auto_in_a_bits_size);
    a_put  = (auto_in_a_bits_opcode == 3'd0) || (auto_in_a_bits_opcode == 3'd1);
    // Lane counting starts at the size-aligned group base; Gets never advance.
    a_lane = (auto_in_a_bits_address[LO+LR-1:LO] & ~a_last) + (a_put ? a_idx : '0);
  end

  assign auto_out_a_valid        = auto_in_a_valid;
  assign auto_out_a_bits_opcode  = auto_in_a_bits_opcode;
  assign auto_out_a_bits_param   = auto_in_a_bits_param;
  assign auto_out_a_bits_size    = auto_in_a_bits_size;
  assign auto_out_a_bits_source  = auto_in_a_bits_source;
  assign auto_out_a_bits_address = auto_in_a_bits_address;
  assign auto_out_a_bits_corrupt = auto_in_a_bits_corrupt;
  assign auto_out_a_bits_mask    = auto_in_a_bits_mask[int'(a_lane)*OUT_BYTES +: OUT_BYTES];
  assign auto_out_a_bits_data    = a_put ? auto_in_a_bits_data[int'(a_lane)*OW +: OW] : '0;
  // The wide beat is consumed only with its final narrow beat.
  assign auto_in_a_ready         = auto_out_a_ready && (!a_put || (a_idx == a_last));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_idx <= '0;
    end else if (auto_in_a_valid && auto_out_a_ready && a_put) begin
      a_idx <= (a_idx == a_last) ? '0 : a_idx + 1'b1;
    end
  end

  // ---------------- D channel gather ----------------
  logic [LR-1:0]           d_idx;
  logic [LR-1:0]           d_last;
  logic                    d_final;
  logic                    den_acc;
  logic                    cor_acc;
  logic [(RATIO-1)*OW-1:0] gather_buf;

  always_comb begin
    // Only AccessAckData gathers; anything else behaves as a one-beat group.
    d_last  = (auto_out_d_bits_opcode == 3'd1) ? grp_last(auto_out_d_bits_size) : '0;
    d_final = (d_idx == d_last);
  end

  assign auto_out_d_ready       = d_final ? auto_in_d_ready : 1'b1;
  assign auto_in_d_valid        = auto_out_d_valid && d_final;
  assign auto_in_d_bits_opcode  = auto_out_d_bits_opcode;
  assign auto_in_d_bits_param   = auto_out_d_bits_param;
  assign auto_in_d_bits_size    = auto_out_d_bits_size;
  assign auto_in_d_bits_source  = auto_out_d_bits_source;
  assign auto_in_d_bits_sink    = auto_out_d_bits_sink;
  assign auto_in_d_bits_denied  = den_acc | auto_out_d_bits_denied;
  assign auto_in_d_bits_corrupt = cor_acc | auto_out_d_bits_corrupt;

  // Wide lane i takes group member (i mod n); member n-1 is the live beat,
  // earlier members come from the buffer. Groups smaller than RATIO repeat.
  always_comb begin
    auto_in_d_bits_data = '0;
    for (int i = 0; i < RATIO; i++) begin
      logic [LR-1:0] sel;
      logic [OW-1:0] lane;
      sel  = LR'(i) & d_last;
      lane = auto_out_d_bits_data;
      for (int k = 0; k < RATIO - 1; k++) begin
        if ((sel != d_last) && (sel == LR'(k))) lane = gather_buf[k*OW +: OW];
      end
      auto_in_d_bits_data[i*OW +: OW] = lane;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      d_idx   <= '0;
      den_acc <= 1'b0;
      cor_acc <= 1'b0;
    end else if (auto_out_d_valid && auto_out_d_ready) begin
      if (d_final) begin
        d_idx   <= '0;
        den_acc <= 1'b0;
        cor_acc <= 1'b0;
      end else begin
        d_idx   <= d_idx + 1'b1;
        den_acc <= den_acc | auto_out_d_bits_denied;
        cor_acc <= cor_acc | auto_out_d_bits_corrupt;
      end
    end
  end

  // Buffer holds data only; its contents are meaningless once d_idx clears.
  always_ff @(posedge clock) begin
    if (auto_out_d_valid && !d_final) begin
      for (int k = 0; k < RATIO - 1; k++) begin
        if (d_idx == LR'(k)) gather_buf[k*OW +: OW] <= auto_out_d_bits_data;
      end
    end
  end

endmodule

// File: tb/tb_tl_width_narrower.sv
// Bench for tl_width_narrower: directed vectors with literal expectations
// plus a cycle-by-cycle behavioural model of the split/gather rules.
module tb_tl_width_narrower;
  localparam int IB = 8, OB = 4, RATIO = 2, AB = 31, SRB = 3, ZB = 3;

  logic            clock = 1'b0;
  logic            reset;
  logic            auto_in_a_ready, auto_in_a_valid;
  logic [2:0]      auto_in_a_bits_opcode, auto_in_a_bits_param;
  logic [ZB-1:0]   auto_in_a_bits_size;
  logic [SRB-1:0]  auto_in_a_bits_source;
  logic [AB-1:0]   auto_in_a_bits_address;
  logic [IB-1:0]   auto_in_a_bits_mask;
  logic [8*IB-1:0] auto_in_a_bits_data;
  logic            auto_in_a_bits_corrupt;
  logic            auto_in_d_ready, auto_in_d_valid;
  logic [2:0]      auto_in_d_bits_opcode;
  logic [1:0]      auto_in_d_bits_param;
  logic [ZB-1:0]   auto_in_d_bits_size;
  logic [SRB-1:0]  auto_in_d_bits_source;
  logic            auto_in_d_bits_sink, auto_in_d_bits_denied, auto_in_d_bits_corrupt;
  logic [8*IB-1:0] auto_in_d_bits_data;
  logic            auto_out_a_ready, auto_out_a_valid;
  logic [2:0]      auto_out_a_bits_opcode, auto_out_a_bits_param;
  logic [ZB-1:0]   auto_out_a_bits_size;
  logic [SRB-1:0]  auto_out_a_bits_source;
  logic [AB-1:0]   auto_out_a_bits_address;
  logic [OB-1:0]   auto_out_a_bits_mask;
  logic [8*OB-1:0] auto_out_a_bits_data;
  logic            auto_out_a_bits_corrupt;
  logic            auto_out_d_ready, auto_out_d_valid;
  logic [2:0]      auto_out_d_bits_opcode;
  logic [1:0]      auto_out_d_bits_param;
  logic [ZB-1:0]   auto_out_d_bits_size;
  logic [SRB-1:0]  auto_out_d_bits_source;
  logic            auto_out_d_bits_sink, auto_out_d_bits_denied, auto_out_d_bits_corrupt;
  logic [8*OB-1:0] auto_out_d_bits_data;

  always #5 clock = ~clock;

  tl_width_narrower #(.IN_BYTES(IB), .OUT_BYTES(OB), .ADDR_BITS(AB),
                      .SOURCE_BITS(SRB), .SIZE_BITS(ZB)) dut (
    .clock(clock), .reset(reset),
    .auto_in_a_ready(auto_in_a_ready), .auto_in_a_valid(auto_in_a_valid),
    .auto_in_a_bits_opcode(auto_in_a_bits_opcode), .auto_in_a_bits_param(auto_in_a_bits_param),
    .auto_in_a_bits_size(auto_in_a_bits_size), .auto_in_a_bits_source(auto_in_a_bits_source),
    .auto_in_a_bits_address(auto_in_a_bits_address), .auto_in_a_bits_mask(auto_in_a_bits_mask),
    .auto_in_a_bits_data(auto_in_a_bits_data), .auto_in_a_bits_corrupt(auto_in_a_bits_corrupt),
    .auto_in_d_ready(auto_in_d_ready), .auto_in_d_valid(auto_in_d_valid),
    .auto_in_d_bits_opcode(auto_in_d_bits_opcode), .auto_in_d_bits_param(auto_in_d_bits_param),
    .auto_in_d_bits_size(auto_in_d_bits_size), .auto_in_d_bits_source(auto_in_d_bits_source),
    .auto_in_d_bits_sink(auto_in_d_bits_sink), .auto_in_d_bits_denied(auto_in_d_bits_denied),
    .auto_in_d_bits_data(auto_in_d_bits_data), .auto_in_d_bits_corrupt(auto_in_d_bits_corrupt),
    .auto_out_a_ready(auto_out_a_ready), .auto_out_a_valid(auto_out_a_valid),
    .auto_out_a_bits_opcode(auto_out_a_bits_opcode), .auto_out_a_bits_param(auto_out_a_bits_param),
    .auto_out_a_bits_size(auto_out_a_bits_size), .auto_out_a_bits_source(auto_out_a_bits_source),
    .auto_out_a_bits_address(auto_out_a_bits_address), .auto_out_a_bits_mask(auto_out_a_bits_mask),
    .auto_out_a_bits_data(auto_out_a_bits_data), .auto_out_a_bits_corrupt(auto_out_a_bits_corrupt),
    .auto_out_d_ready(auto_out_d_ready), .auto_out_d_valid(auto_out_d_valid),
    .auto_out_d_bits_opcode(auto_out_d_bits_opcode), .auto_out_d_bits_param(auto_out_d_bits_param),
    .auto_out_d_bits_size(auto_out_d_bits_size), .auto_out_d_bits_source(auto_out_d_bits_source),
    .auto_out_d_bits_sink(auto_out_d_bits_sink), .auto_out_d_bits_denied(auto_out_d_bits_denied),
    .auto_out_d_bits_data(auto_out_d_bits_data), .auto_out_d_bits_corrupt(auto_out_d_bits_corrupt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Narrow beats per group: transfer bytes / narrow width, clamped to [1, RATIO].
  function automatic int grp(input int size);
    int n;
    n = (1 << size) / OB;
    if (n < 1) n = 1;
    if (n > RATIO) n = RATIO;
    return n;
  endfunction

  typedef struct { logic [31:0] data; logic den; logic cor; } nb_t;
  nb_t hist[$];
  int  a_seen;

  // Behavioural model: A lane choice from address/size/beat count; D wide beat
  // from the list of narrow beats accepted so far in the current group.
  always @(negedge clock) begin : cmp
    int n, s, lane, dn;
    logic put, last, den, cor;
    logic [63:0] sh, wide;
    logic [31:0] lanes[$];
    if (reset) begin
      a_seen = 0;
      hist.delete();
    end else begin
      chk("a_valid", auto_out_a_valid, auto_in_a_valid);
      if (auto_in_a_valid) begin
        n    = grp(int'(auto_in_a_bits_size));
        s    = (int'(auto_in_a_bits_address) / OB) % RATIO;
        s    = s - (s % n);
        put  = auto_in_a_bits_opcode <= 3'd1;
        lane = put ? s + a_seen : s;
        sh   = auto_in_a_bits_data >> (lane * 32);
        chk("a_data", auto_out_a_bits_data, put ? sh[31:0] : 32'h0);
        sh   = 64'(auto_in_a_bits_mask) >> (lane * 4);
        chk("a_mask", auto_out_a_bits_mask, sh[3:0]);
        chk("a_ready", auto_in_a_ready, auto_out_a_ready && (!put || a_seen == n - 1));
        chk("a_addr", auto_out_a_bits_address, auto_in_a_bits_address);
        chk("a_hdr", {auto_out_a_bits_opcode, auto_out_a_bits_size, auto_out_a_bits_source, auto_out_a_bits_corrupt},
                     {auto_in_a_bits_opcode, auto_in_a_bits_size, auto_in_a_bits_source, auto_in_a_bits_corrupt});
        if (auto_out_a_ready && put) a_seen = (a_seen == n - 1) ? 0 : a_seen + 1;
      end
      if (auto_out_d_valid) begin
        dn   = (auto_out_d_bits_opcode == 3'd1) ? grp(int'(auto_out_d_bits_size)) : 1;
        last = (hist.size() == dn - 1);
        chk("d_out_ready", auto_out_d_ready, last ? auto_in_d_ready : 1'b1);
        chk("d_in_valid", auto_in_d_valid, last);
        if (last) begin
          lanes.delete();
          den = auto_out_d_bits_denied;
          cor = auto_out_d_bits_corrupt;
          foreach (hist[i]) begin
            lanes.push_back(hist[i].data);
            den |= hist[i].den;
            cor |= hist[i].cor;
          end
          lanes.push_back(auto_out_d_bits_data);
          wide = '0;
          for (int i = 0; i < RATIO; i++) wide |= 64'(lanes[i % dn]) << (i * 32);
          chk("d_data", auto_in_d_bits_data, wide);
          chk("d_denied", auto_in_d_bits_denied, den);
          chk("d_corrupt", auto_in_d_bits_corrupt, cor);
          chk("d_hdr", {auto_in_d_bits_opcode, auto_in_d_bits_size, auto_in_d_bits_source, auto_in_d_bits_sink},
                       {auto_out_d_bits_opcode, auto_out_d_bits_size, auto_out_d_bits_source, auto_out_d_bits_sink});
        end
        if (auto_out_d_ready) begin
          if (last) hist.delete();
          else hist.push_back('{auto_out_d_bits_data, auto_out_d_bits_denied, auto_out_d_bits_corrupt});
        end
      end else begin
        chk("d_idle", auto_in_d_valid, 1'b0);
      end
    end
  end

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic a_drive(input logic [2:0] op, input logic [2:0] size, input logic [30:0] addr,
                         input logic [7:0] mask, input logic [63:0] data);
    auto_in_a_valid        = 1'b1;
    auto_in_a_bits_opcode  = op;
    auto_in_a_bits_size    = size;
    auto_in_a_bits_address = addr;
    auto_in_a_bits_mask    = mask;
    auto_in_a_bits_data    = data;
    auto_in_a_bits_source  = 3'd5;
  endtask

  task automatic d_drive(input logic [2:0] op, input logic [2:0] size, input logic [31:0] data,
                         input logic den, input logic cor);
    auto_out_d_valid        = 1'b1;
    auto_out_d_bits_opcode  = op;
    auto_out_d_bits_size    = size;
    auto_out_d_bits_data    = data;
    auto_out_d_bits_denied  = den;
    auto_out_d_bits_corrupt = cor;
    auto_out_d_bits_source  = 3'd5;
  endtask

  initial begin
    reset = 1'b1;
    auto_in_a_valid = 0; auto_in_a_bits_opcode = 0; auto_in_a_bits_param = 0; auto_in_a_bits_size = 0;
    auto_in_a_bits_source = 0; auto_in_a_bits_address = 0; auto_in_a_bits_mask = 0;
    auto_in_a_bits_data = 0; auto_in_a_bits_corrupt = 0; auto_in_d_ready = 1; auto_out_a_ready = 1;
    auto_out_d_valid = 0; auto_out_d_bits_opcode = 0; auto_out_d_bits_param = 0; auto_out_d_bits_size = 0;
    auto_out_d_bits_source = 0; auto_out_d_bits_sink = 0; auto_out_d_bits_denied = 0;
    auto_out_d_bits_data = 0; auto_out_d_bits_corrupt = 0;

    // Reset state
    step;
    @(negedge clock);
    chk("rst_in_a_ready", auto_in_a_ready, 1'b1);
    chk("rst_in_d_valid", auto_in_d_valid, 1'b0);
    d_drive(3'd1, 3'd3, 32'h0, 1'b0, 1'b0);
    #1;
    chk("rst_out_d_ready", auto_out_d_ready, 1'b1);
    chk("rst_gather_vld", auto_in_d_valid, 1'b0);
    auto_out_d_valid = 0;
    step;
    reset = 1'b0;

    // 1: PutFull size 3 split into two lanes
    a_drive(3'd0, 3'd3, 31'h100, 8'hFF, 64'h1122334455667788);
    @(negedge clock);
    chk("t1_b1_data", auto_out_a_bits_data, 32'h55667788);
    chk("t1_b1_mask", auto_out_a_bits_mask, 4'hF);
    chk("t1_b1_ready", auto_in_a_ready, 1'b0);
    step;
    @(negedge clock);
    chk("t1_b2_data", auto_out_a_bits_data, 32'h11223344);
    chk("t1_b2_ready", auto_in_a_ready, 1'b1);
    step;

    // 2: PutPartial size 2 in the upper lane, with one stall cycle
    a_drive(3'd1, 3'd2, 31'h104, 8'hF0, 64'hDEADBEEF01234567);
    auto_out_a_ready = 0;
    @(negedge clock);
    chk("t2_stall_ready", auto_in_a_ready, 1'b0);
    step;
    auto_out_a_ready = 1;
    @(negedge clock);
    chk("t2_data", auto_out_a_bits_data, 32'hDEADBEEF);
    chk("t2_mask", auto_out_a_bits_mask, 4'hF);
    chk("t2_ready", auto_in_a_ready, 1'b1);
    step;

    // 3: Get size 3, then two-beat AccessAckData with corrupt on beat 1
    a_drive(3'd4, 3'd3, 31'h100, 8'hFF, 64'h0123456789ABCDEF);
    @(negedge clock);
    chk("t3_get_data", auto_out_a_bits_data, 32'h0);
    chk("t3_get_ready", auto_in_a_ready, 1'b1);
    step;
    auto_in_a_valid = 0;
    d_drive(3'd1, 3'd3, 32'hAAAA0000, 1'b0, 1'b1);
    @(negedge clock);
    chk("t3_b1_vld", auto_in_d_valid, 1'b0);
    step;
    d_drive(3'd1, 3'd3, 32'hBBBB1111, 1'b0, 1'b0);
    @(negedge clock);
    chk("t3_vld", auto_in_d_valid, 1'b1);
    chk("t3_data", auto_in_d_bits_data, 64'hBBBB1111AAAA0000);
    chk("t3_corrupt", auto_in_d_bits_corrupt, 1'b1);
    chk("t3_denied", auto_in_d_bits_denied, 1'b0);
    step;

    // 4: single-beat response replicated, plus an AccessAck pass-through
    d_drive(3'd1, 3'd2, 32'hCAFEF00D, 1'b0, 1'b0);
    @(negedge clock);
    chk("t4_vld", auto_in_d_valid, 1'b1);
    chk("t4_data", auto_in_d_bits_data, 64'hCAFEF00DCAFEF00D);
    step;
    d_drive(3'd0, 3'd3, 32'h12345678, 1'b1, 1'b0);
    @(negedge clock);
    chk("t4_ack_vld", auto_in_d_valid, 1'b1);
    chk("t4_ack_denied", auto_in_d_bits_denied, 1'b1);
    step;

    // D backpressure on the last beat, then a back-to-back group
    d_drive(3'd1, 3'd3, 32'h01010101, 1'b1, 1'b0);
    step;
    d_drive(3'd1, 3'd3, 32'h02020202, 1'b0, 1'b0);
    auto_in_d_ready = 0;
    @(negedge clock);
    chk("bp_out_ready", auto_out_d_ready, 1'b0);
    step;
    step;
    auto_in_d_ready = 1;
    @(negedge clock);
    chk("bp_data", auto_in_d_bits_data, 64'h0202020201010101);
    chk("bp_denied", auto_in_d_bits_denied, 1'b1);
    step;
    d_drive(3'd1, 3'd3, 32'h03030303, 1'b0, 1'b0);
    step;
    d_drive(3'd1, 3'd3, 32'h04040404, 1'b0, 1'b0);
    @(negedge clock);
    chk("b2b_data", auto_in_d_bits_data, 64'h0404040403030303);
    step;
    auto_out_d_valid = 0;

    // 5: PutFull with 3-cycle stall on beat 2
    a_drive(3'd0, 3'd3, 31'h200, 8'hFF, 64'hA1A2A3A4B1B2B3B4);
    @(negedge clock);
    chk("t5_b1_data", auto_out_a_bits_data, 32'hB1B2B3B4);
    step;
    auto_out_a_ready = 0;
    repeat (3) begin
      @(negedge clock);
      chk("t5_hold_data", auto_out_a_bits_data, 32'hA1A2A3A4);
      chk("t5_hold_ready", auto_in_a_ready, 1'b0);
      step;
    end
    auto_out_a_ready = 1;
    @(negedge clock);
    chk("t5_b2_ready", auto_in_a_ready, 1'b1);
    chk("t5_b2_data", auto_out_a_bits_data, 32'hA1A2A3A4);
    step;

    // Two-wide-beat burst (size 4) with a simultaneous D single beat
    a_drive(3'd0, 3'd4, 31'h300, 8'hFF, 64'h0807060504030201);
    d_drive(3'd1, 3'd2, 32'h77778888, 1'b0, 1'b0);
    step;
    auto_out_d_valid = 0;
    step;
    a_drive(3'd0, 3'd4, 31'h300, 8'h3C, 64'h1817161514131211);
    @(negedge clock);
    chk("burst_b3_mask", auto_out_a_bits_mask, 4'hC);
    step;
    @(negedge clock);
    chk("burst_b4_data", auto_out_a_bits_data, 32'h18171615);
    step;
    auto_in_a_valid = 0;

    // 6: reset in the middle of a D group
    d_drive(3'd1, 3'd3, 32'h11112222, 1'b1, 1'b0);
    @(negedge clock);
    chk("t6_b1_vld", auto_in_d_valid, 1'b0);
    step;
    auto_out_d_valid = 0;
    reset = 1'b1;
    @(negedge clock);
    chk("t6_rst_vld", auto_in_d_valid, 1'b0);
    step;
    reset = 1'b0;
    d_drive(3'd1, 3'd3, 32'h33334444, 1'b0, 1'b0);
    @(negedge clock);
    chk("t6_first_vld", auto_in_d_valid, 1'b0);
    step;
    d_drive(3'd1, 3'd3, 32'h55556666, 1'b0, 1'b0);
    @(negedge clock);
    chk("t6_vld", auto_in_d_valid, 1'b1);
    chk("t6_data", auto_in_d_bits_data, 64'h5555666633334444);
    chk("t6_denied", auto_in_d_bits_denied, 1'b0);
    step;
    auto_out_d_valid = 0;
    step;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
